// File: rtl/disp_pkg.sv
// disp_pkg: shared state encoding, digit count and DIN field layout for the display value writer.
package disp_pkg;
    typedef enum logic [1:0] {IDLE, CONVERT, WRITE, DONE} state_t;
    localparam int DIGITS = 8;
    localparam int ADDR_W = 3;
    localparam int EN_BIT = 5;
    localparam int BCD_MSB = 4;
    localparam int BCD_LSB = 1;
    localparam int DP_BIT = 0;
endpackage

// File: rtl/display_value_writer_if.sv
// display_value_writer_if: request side (start/value/dp) and display-RAM write port of the value writer.
interface display_value_writer_if #(parameter int WIDTH = 26);
    import disp_pkg::*;
    logic start;
    logic [WIDTH-1:0] value;
    logic dp_en;
    logic [ADDR_W-1:0] dp_pos;
    logic busy;
    logic done;
    logic W;
    logic [ADDR_W-1:0] WADD;
    logic [5:0] DIN;
    modport master(output start, value, dp_en, dp_pos, input busy, done, W, WADD, DIN);
    modport slave(input start, value, dp_en, dp_pos, output busy, done, W, WADD, DIN);
endinterface

// File: rtl/bcd_add3_adjust.sv
// bcd_add3_adjust: double-dabble nibble correction, adds 3 to any BCD digit of 5 or more.
module bcd_add3_adjust (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/display_value_writer.sv
// display_value_writer: binary-to-BCD by double-dabble, then streams 8 digit words into display RAM.
// Optional leading-zero blanking is enabled by defining DISP_LZ_BLANK_EN.
module display_value_writer
    import disp_pkg::*;
#(
    parameter int WIDTH = 26
) (
    input logic clk,
    input logic rst,
    display_value_writer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    state_t state;
    logic [WIDTH-1:0] shreg;
    logic [31:0] bcd;
    logic [31:0] adj;
    logic [31:0] bcd_next;
    logic [CW-1:0] cnt;
    logic dp_en_q;
    logic [ADDR_W-1:0] dp_pos_q;
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_add3_adjust u_adj (.d(bcd[4*i +: 4]), .q(adj[4*i +: 4]));
    end
    assign bcd_next = {adj[30:0], shreg[WIDTH-1]};
    function automatic logic [5:0] digit_word(input logic [31:0] b, input logic [ADDR_W-1:0] i);
        logic [5:0] w;
        w = '0;
        w[EN_BIT] = 1'b1;
        w[BCD_MSB:BCD_LSB] = b[{i, 2'b00} +: 4];
        w[DP_BIT] = dp_en_q && i == dp_pos_q;
`ifdef DISP_LZ_BLANK_EN
        // a zero digit stays visible when it sits between the DP and the units digit
        if (i != '0 && (b >> {i, 2'b00}) == 32'd0 && !(dp_en_q && i <= dp_pos_q)) w = '0;
`endif
        return w;
    endfunction
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.W <= 1'b0;
            bus.WADD <= '0;
            bus.DIN <= '0;
            shreg <= '0;
            bcd <= '0;
            cnt <= '0;
            dp_en_q <= 1'b0;
            dp_pos_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    shreg <= bus.value;
                    dp_en_q <= bus.dp_en;
                    dp_pos_q <= bus.dp_pos;
                    bcd <= '0;
                    cnt <= '0;
                    bus.busy <= 1'b1;
                    state <= CONVERT;
                end
                CONVERT: begin
                    bcd <= bcd_next;
                    shreg <= shreg << 1;
                    cnt <= cnt + 1'b1;
                    // the final shift result feeds digit 0 directly so WRITE starts without a gap
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= WRITE;
                        bus.W <= 1'b1;
                        bus.WADD <= '0;
                        bus.DIN <= digit_word(bcd_next, '0);
                    end
                end
                WRITE: if (bus.WADD == ADDR_W'(DIGITS - 1)) begin
                    bus.W <= 1'b0;
                    bus.done <= 1'b1;
                    state <= DONE;
                end else begin
                    bus.WADD <= bus.WADD + 1'b1;
                    bus.DIN <= digit_word(bcd, bus.WADD + 1'b1);
                end
                default: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_display_value_writer.sv
// tb_display_value_writer: directed vector table plus hand-written sequences for ignored start, mid-write reset and held start.
module tb_display_value_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    display_value_writer_if #(.WIDTH(26)) bus();
    display_value_writer #(.WIDTH(26)) dut(.clk(clk), .rst(rst), .bus(bus));
`ifdef DISP_LZ_BLANK_EN
    localparam logic [5:0] LZ = 6'h00;
`else
    localparam logic [5:0] LZ = 6'h20;
`endif
    typedef struct {
        logic [25:0] value;
        logic dp_en;
        logic [2:0] dp_pos;
        logic [7:0][5:0] exp;
    } vec_t;
    vec_t vecs [6];
    int passed = 0;
    int total = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic run_op(input vec_t v, input bit pulse, input string tag);
        logic [5:0] got [8];
        int writes = 0;
        int done_n = 0;
        int done_at = 0;
        int order_err = 0;
        int busy_err = 0;
        for (int i = 0; i < 8; i++) got[i] = 6'h3f;
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = v.value;
        bus.dp_en = v.dp_en;
        bus.dp_pos = v.dp_pos;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.value = ~v.value;
        bus.dp_en = ~v.dp_en;
        bus.dp_pos = v.dp_pos + 3'd3;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.W) begin
                if (bus.WADD != 3'(writes) || k != 27 + writes) order_err++;
                got[bus.WADD] = bus.DIN;
                writes++;
            end
            if (bus.done) begin
                done_n++;
                done_at = k;
            end
            if (bus.busy != (k <= 35)) busy_err++;
            bus.start = pulse && (k == 5 || k == 30);
        end
        bus.start = 1'b0;
        chk({tag, " writes"}, writes, 8);
        chk({tag, " order"}, order_err, 0);
        chk({tag, " done_count"}, done_n, 1);
        chk({tag, " done_cycle"}, done_at, 35);
        chk({tag, " busy"}, busy_err, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("%s din[%0d]", tag, i), 32'(got[i]), 32'(v.exp[i]));
    endtask
    initial begin
        int err;
        int dn;
        vecs[0] = '{26'd1234, 1'b0, 3'd0, {LZ, LZ, LZ, LZ, 6'h22, 6'h24, 6'h26, 6'h28}};
        vecs[1] = '{26'd5, 1'b1, 3'd2, {LZ, LZ, LZ, LZ, LZ, 6'h21, 6'h20, 6'h2A}};
        vecs[2] = '{26'd0, 1'b0, 3'd0, {LZ, LZ, LZ, LZ, LZ, LZ, LZ, 6'h20}};
        vecs[3] = '{26'd67108863, 1'b0, 3'd0, {6'h2C, 6'h2E, 6'h22, 6'h20, 6'h30, 6'h30, 6'h2C, 6'h26}};
        vecs[4] = '{26'd90, 1'b1, 3'd5, {LZ, LZ, 6'h21, 6'h20, 6'h20, 6'h20, 6'h32, 6'h20}};
        vecs[5] = '{26'd1000, 1'b1, 3'd0, {LZ, LZ, LZ, LZ, 6'h22, 6'h20, 6'h20, 6'h21}};
        bus.start = 1'b0;
        bus.value = '0;
        bus.dp_en = 1'b0;
        bus.dp_pos = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset done", 32'(bus.done), 0);
        chk("reset W", 32'(bus.W), 0);
        chk("reset WADD", 32'(bus.WADD), 0);
        chk("reset DIN", 32'(bus.DIN), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));
        run_op(vecs[0], 1'b1, "ignored_start");
        // reset lands on the third write cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = vecs[3].value;
        bus.dp_en = 1'b0;
        bus.dp_pos = '0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 29; k++) @(negedge clk);
        chk("pre_rst W", 32'(bus.W), 1);
        chk("pre_rst WADD", 32'(bus.WADD), 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst W", 32'(bus.W), 0);
        chk("rst busy", 32'(bus.busy), 0);
        rst = 1'b0;
        run_op(vecs[0], 1'b0, "after_rst");
        // held start: one IDLE cycle between operations
        @(negedge clk);
        bus.start = 1'b1;
        bus.value = 26'd7;
        @(posedge clk);
        #1;
        err = 0;
        dn = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.busy != (k % 36 != 0)) err++;
            if (bus.done) begin
                dn++;
                if (k % 36 != 35) err++;
            end
        end
        bus.start = 1'b0;
        chk("held busy_pattern", err, 0);
        chk("held done_count", dn, 2);
        repeat (20) @(negedge clk);
        chk("held idle busy", 32'(bus.busy), 0);
        chk("held idle W", 32'(bus.W), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
